// File: rtl/nn_harness_pkg.sv
//------------------------------------------------------------------------------
// nn_harness_pkg - shared types and default sizes for the frame harness. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package nn_harness_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int N_IN_DEF  = 16;
    localparam int N_OUT_DEF = 5;
    localparam int IDXW      = $clog2(N_IN_DEF);
    localparam int OUTW      = $clog2(N_OUT_DEF);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        LAUNCH  = 2'd1,
        WAIT    = 2'd2,
        DRAIN   = 2'd3
    } state_t;

    typedef logic signed [WIDTH_DEF-1:0] elem_t;

endpackage

`default_nettype wire

// File: rtl/nn_argmax_signed.sv
//------------------------------------------------------------------------------
// nn_argmax_signed - combinational signed argmax, ties resolve to lowest index. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module nn_argmax_signed #(
    parameter int WIDTH = 16,
    parameter int N_OUT = 5,
    parameter int OUTW  = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic [N_OUT*WIDTH-1:0] vec,
    output logic [OUTW-1:0]        idx
);

    logic signed [WIDTH-1:0] best;

    // Strict greater-than keeps the earliest channel on ties.
    always_comb begin
        best = $signed(vec[0 +: WIDTH]);
        idx  = '0;
        for (int k = 1; k < N_OUT; k++) begin
            if ($signed(vec[k*WIDTH +: WIDTH]) > best) begin
                best = $signed(vec[k*WIDTH +: WIDTH]);
                idx  = OUTW'(k);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/nn_frame_harness.sv
//------------------------------------------------------------------------------
// nn_frame_harness - packs a sample stream for an ap_ctrl_hs core and drains results. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module nn_frame_harness
    import nn_harness_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int N_IN    = N_IN_DEF,
    parameter int N_OUT   = N_OUT_DEF,
    parameter int TIMEOUT = 1024,
    parameter int LATW    = 16,
    parameter int CNTW    = 32
) (
    input  logic                   ap_clk,
    input  logic                   ap_rst,
    input  logic                   cfg_argmax,
    input  logic [WIDTH-1:0]       s_data,
    input  logic                   s_valid,
    input  logic                   s_last,
    output logic                   s_ready,
    output logic                   core_start,
    output logic                   core_in_vld,
    output logic [N_IN*WIDTH-1:0]  core_in,
    input  logic                   core_ready,
    input  logic                   core_done,
    input  logic [N_OUT*WIDTH-1:0] core_out,
    input  logic [N_OUT-1:0]       core_out_vld,
    output logic [WIDTH-1:0]       m_data,
    output logic                   m_valid,
    output logic                   m_last,
    input  logic                   m_ready,
    output logic [CNTW-1:0]        frame_cnt,
    output logic [LATW-1:0]        last_latency,
    output logic [N_OUT-1:0]       missing_vld,
    output logic                   err_timeout,
    output logic                   err_frame
);

    localparam int              IW        = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int              OW        = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam logic [IW-1:0]   IDX_LAST  = IW'(N_IN - 1);
    localparam logic [OW-1:0]   WORD_LAST = OW'(N_OUT - 1);
    localparam logic [LATW-1:0] LAT_LIMIT = LATW'(TIMEOUT);

    state_t                 state, state_nxt;
    logic [IW-1:0]          idx;
    logic [OW-1:0]          word;
    logic [LATW-1:0]        lat;
    logic                   argmax_mode;
    logic [N_OUT-1:0]       vld_seen;
    logic [WIDTH-1:0]       capture [N_OUT];
    logic [N_OUT*WIDTH-1:0] capture_flat;
    logic [OW-1:0]          amax_idx;
    logic                   accept;

    generate
        for (genvar k = 0; k < N_OUT; k++) begin : g_flat
            assign capture_flat[k*WIDTH +: WIDTH] = capture[k];
        end
    endgenerate

    nn_argmax_signed #(
        .WIDTH (WIDTH),
        .N_OUT (N_OUT),
        .OUTW  (OW)
    ) u_argmax (
        .vec (capture_flat),
        .idx (amax_idx)
    );

    always_ff @(posedge ap_clk or negedge ap_rst) begin
        if (!ap_rst) state <= COLLECT;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        core_start  = 1'b0;
        core_in_vld = 1'b0;
        m_valid     = 1'b0;
        m_last      = 1'b0;
        m_data      = '0;
        accept      = s_valid && s_ready && (state == COLLECT);
        case (state)
            COLLECT: if (accept && idx == IDX_LAST && s_last) state_nxt = LAUNCH;
            LAUNCH: begin
                core_start  = 1'b1;
                core_in_vld = 1'b1;
                if (core_ready) state_nxt = WAIT;
            end
            WAIT: begin
                if (core_done)              state_nxt = DRAIN;
                else if (lat >= LAT_LIMIT)  state_nxt = COLLECT;
            end
            DRAIN: begin
                m_valid = 1'b1;
                m_last  = argmax_mode || (word == WORD_LAST);
                m_data  = argmax_mode ? {{(WIDTH-OW){1'b0}}, amax_idx} : capture[word];
                if (m_ready && m_last) state_nxt = COLLECT;
            end
            default: state_nxt = COLLECT;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst) begin
        if (!ap_rst) begin
            s_ready      <= 1'b0;
            core_in      <= '0;
            idx          <= '0;
            word         <= '0;
            lat          <= '0;
            argmax_mode  <= 1'b0;
            vld_seen     <= '0;
            frame_cnt    <= '0;
            last_latency <= '0;
            missing_vld  <= '0;
            err_timeout  <= 1'b0;
            err_frame    <= 1'b0;
            for (int k = 0; k < N_OUT; k++) capture[k] <= '0;
        end else begin
            // s_ready is registered so it stays low through reset and rises one edge later.
            s_ready     <= (state_nxt == COLLECT);
            err_timeout <= 1'b0;
            err_frame   <= 1'b0;
            case (state)
                COLLECT: begin
                    if (accept) begin
                        core_in[idx*WIDTH +: WIDTH] <= s_data;
                        if (idx == IDX_LAST || s_last) begin
                            idx       <= '0;
                            err_frame <= !(idx == IDX_LAST && s_last);
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                    if (state_nxt == LAUNCH) lat <= LATW'(1);
                end
                LAUNCH: begin
                    argmax_mode <= cfg_argmax;
                    vld_seen    <= '0;
                    missing_vld <= '0;
                    word        <= '0;
                    for (int k = 0; k < N_OUT; k++) capture[k] <= '0;
                    lat <= (lat == '1) ? lat : lat + 1'b1;
                end
                WAIT: begin
                    for (int k = 0; k < N_OUT; k++) begin
                        if (core_out_vld[k]) capture[k] <= core_out[k*WIDTH +: WIDTH];
                    end
                    vld_seen <= vld_seen | core_out_vld;
                    lat      <= (lat == '1) ? lat : lat + 1'b1;
                    if (core_done) begin
                        last_latency <= lat;
                        missing_vld  <= ~(vld_seen | core_out_vld);
                    end else if (lat >= LAT_LIMIT) begin
                        err_timeout <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (m_ready) begin
                        if (m_last) begin
                            frame_cnt <= frame_cnt + 1'b1;
                            word      <= '0;
                        end else begin
                            word <= word + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_nn_frame_harness.sv
//------------------------------------------------------------------------------
// tb_nn_frame_harness - directed vectors for the frame harness with a simple core model. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_nn_frame_harness;

    logic         clk = 1'b0;
    logic         ap_rst;
    logic         cfg_argmax;
    logic [15:0]  s_data;
    logic         s_valid, s_last, s_ready;
    logic         core_start, core_in_vld;
    logic [255:0] core_in;
    logic         core_ready, core_done;
    logic [79:0]  core_out;
    logic [4:0]   core_out_vld;
    logic [15:0]  m_data;
    logic         m_valid, m_last, m_ready;
    logic [31:0]  frame_cnt;
    logic [15:0]  last_latency;
    logic [4:0]   missing_vld;
    logic         err_timeout, err_frame;

    int vectors = 0, miscompares = 0;
    int launches = 0, nerrf = 0, nerrt = 0, nmv = 0;
    int outv [5];
    logic [4:0]  vld_mask;
    bit          core_hang;
    logic [15:0] ex [5];

    always #5 clk = ~clk;

    nn_frame_harness dut (
        .ap_clk(clk), .ap_rst(ap_rst), .cfg_argmax(cfg_argmax),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .core_start(core_start), .core_in_vld(core_in_vld), .core_in(core_in),
        .core_ready(core_ready), .core_done(core_done), .core_out(core_out),
        .core_out_vld(core_out_vld), .m_data(m_data), .m_valid(m_valid),
        .m_last(m_last), .m_ready(m_ready), .frame_cnt(frame_cnt),
        .last_latency(last_latency), .missing_vld(missing_vld),
        .err_timeout(err_timeout), .err_frame(err_frame)
    );

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Core model: ready on the start cycle, outputs and done seven cycles later.
    initial begin
        core_ready = 0; core_done = 0; core_out_vld = '0; core_out = '0;
        forever begin
            @(negedge clk);
            core_ready = 0; core_done = 0; core_out_vld = '0;
            if (core_start && ap_rst) begin
                core_ready = 1;
                launches++;
                @(negedge clk);
                core_ready = 0;
                if (!core_hang) begin
                    repeat (6) @(negedge clk);
                    for (int k = 0; k < 5; k++) core_out[k*16 +: 16] = outv[k][15:0];
                    core_out_vld = vld_mask;
                    core_done    = 1;
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (err_frame)   nerrf++;
        if (err_timeout) nerrt++;
        if (m_valid)     nmv++;
    end

    task automatic send(input int n, input int last_pos);
        for (int i = 0; i < n; i++) begin
            int t = 0;
            s_data = 16'(i); s_valid = 1; s_last = (i == last_pos);
            while (!s_ready && t < 100) begin @(negedge clk); t++; end
            if (!s_ready) chk("s_ready_wait", s_ready, 1);
            @(negedge clk);
        end
        s_valid = 0; s_last = 0;
    endtask

    task automatic drain(input int n, input int stall_at);
        for (int k = 0; k < n; k++) begin
            int t = 0;
            while (!m_valid && t < 100) begin @(negedge clk); t++; end
            chk("m_valid", m_valid, 1);
            chk($sformatf("word%0d", k), m_data, ex[k]);
            chk($sformatf("last%0d", k), m_last, (k == n - 1));
            if (k == stall_at) begin
                repeat (4) begin
                    @(negedge clk);
                    chk("stall_hold", {m_valid, m_data}, {1'b1, ex[k]});
                end
            end
            m_ready = 1;
            @(negedge clk);
            m_ready = 0;
        end
        chk("m_valid_after", m_valid, 0);
    endtask

    task automatic set_outs(input int a, input int b, input int c, input int d, input int e);
        outv[0] = a; outv[1] = b; outv[2] = c; outv[3] = d; outv[4] = e;
    endtask

    initial begin
        logic [255:0] exp_in;
        int l0, mv0, t;
        ap_rst = 0; cfg_argmax = 0; s_data = 0; s_valid = 0; s_last = 0; m_ready = 0;
        vld_mask = 5'b11111; core_hang = 0;
        set_outs(-304, 378, 253, -8, 123);
        repeat (3) @(negedge clk);
        chk("rst_outs", {s_ready, core_start, m_valid, frame_cnt, core_in}, '0);
        ap_rst = 1;
        @(negedge clk);
        chk("ready_after_rst", s_ready, 1);

        // Frame 1: plain streaming drain
        send(16, 15);
        for (int i = 0; i < 16; i++) exp_in[i*16 +: 16] = 16'(i);
        chk("core_in", core_in, exp_in);
        chk("launch", {core_start, core_in_vld, s_ready}, 3'b110);
        for (int k = 0; k < 5; k++) ex[k] = 16'(outv[k]);
        drain(5, -1);
        chk("latency", last_latency, 8);
        chk("frame_cnt1", frame_cnt, 1);
        chk("missing1", missing_vld, 0);

        // Frame 2: argmax mode
        cfg_argmax = 1;
        send(16, 15);
        ex[0] = 16'd1;
        drain(1, -1);
        chk("frame_cnt2", frame_cnt, 2);

        // Frame 3: all ties resolve to channel 0
        set_outs(100, 100, 100, 100, 100);
        send(16, 15);
        ex[0] = 16'd0;
        drain(1, -1);
        cfg_argmax = 0;

        // Frame 4: back-pressure on word 2
        set_outs(-304, 378, 253, -8, 123);
        for (int k = 0; k < 5; k++) ex[k] = 16'(outv[k]);
        send(16, 15);
        drain(5, 2);
        chk("frame_cnt4", frame_cnt, 4);

        // Early s_last, then a clean frame
        l0 = launches;
        send(10, 9);
        repeat (2) @(negedge clk);
        chk("err_frame_cnt", nerrf, 1);
        chk("no_launch_err", launches, l0);
        send(16, 15);
        drain(5, -1);
        chk("one_launch", launches, l0 + 1);
        chk("frame_cnt5", frame_cnt, 5);

        // Core hangs
        core_hang = 1;
        mv0 = nmv;
        send(16, 15);
        t = 0;
        while (!err_timeout && t < 2000) begin @(negedge clk); t++; end
        chk("timeout_cycles", t, 1024);
        chk("timeout_ready", s_ready, 1);
        chk("timeout_no_mvalid", nmv, mv0);
        chk("frame_cnt_to", frame_cnt, 5);
        chk("err_to_cnt", nerrt, 1);
        core_hang = 0;

        // Channel 3 vld withheld
        vld_mask = 5'b10111;
        send(16, 15);
        ex[3] = 16'd0;
        drain(5, -1);
        chk("missing3", missing_vld, 5'b01000);
        vld_mask = 5'b11111;
        ex[3] = 16'(outv[3]);

        // Asynchronous reset while waiting on the core
        send(16, 15);
        repeat (3) @(negedge clk);
        #2 ap_rst = 0;
        #1 chk("async_rst", {s_ready, core_start, core_in_vld, m_valid, frame_cnt,
                             last_latency, missing_vld, core_in}, '0);
        repeat (10) @(negedge clk);
        ap_rst = 1;
        @(negedge clk);
        chk("ready_after_rst2", s_ready, 1);
        send(16, 15);
        drain(5, -1);
        chk("frame_cnt_post", frame_cnt, 1);
        chk("latency_post", last_latency, 8);
        chk("err_frame_total", nerrf, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
